// File: rtl/gat_sched_pkg.sv
//==============================================================================
// Module  : gat_sched_pkg
// Brief   : Shared types and constants for the GAT layer scheduler.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

package gat_sched_pkg;

    // Scheduler sequence: three load segments, launch, wait, then drain
    typedef enum logic [3:0] {
        S_IDLE,
        S_LD_H,
        S_LD_NODE,
        S_LD_WGT,
        S_LAUNCH,
        S_RUN,
        S_RD_ISSUE,
        S_RD_WAIT,
        S_RD_OUT
    } state_e;

    // Which load BRAM the segment loader is currently writing
    typedef enum logic [1:0] {
        SEG_H,
        SEG_NODE,
        SEG_WGT
    } seg_e;

    // BRAM ports are byte addressed with 32-bit words
    localparam int BYTE_SHIFT = 2;

    // True when a segment of len_words words cannot fit below 2^addr_w bytes
    function automatic logic len_overflows(input logic [63:0] len_words, input int addr_w);
        return (len_words << BYTE_SHIFT) > (64'd1 << addr_w);
    endfunction

endpackage

`default_nettype wire

// File: rtl/gat_sched_seg_loader.sv
//==============================================================================
// Module  : gat_sched_seg_loader
// Brief   : Streams host words into one of three load BRAMs, selected by
//           segment, and keeps the per-segment load-done flags.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module gat_sched_seg_loader
    import gat_sched_pkg::*;
#(
    parameter int TOP_WIDTH = 32,
    parameter int LEN_W     = 20,
    parameter int ADDR_W    = 22
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear_i,
    input  logic                 active_i,
    input  seg_e                 seg_i,
    input  logic [LEN_W-1:0]     len_i,
    input  logic [TOP_WIDTH-1:0] s_data_i,
    input  logic                 s_valid_i,
    output logic                 s_ready_o,
    output logic [TOP_WIDTH-1:0] bram_din_o,
    output logic                 h_data_ena_o,
    output logic                 h_node_ena_o,
    output logic                 wgt_ena_o,
    output logic                 bram_wea_o,
    output logic [ADDR_W-1:0]    bram_addra_o,
    output logic                 h_data_done_o,
    output logic                 h_node_done_o,
    output logic                 wgt_done_o,
    output logic                 seg_last_o
);

    logic [LEN_W-1:0] idx_q;
    logic             w_beat;
    logic             w_last_idx;

    // A zero-length segment never accepts words so no beat is swallowed
    assign s_ready_o  = active_i && (len_i != '0);
    assign w_beat     = s_valid_i && s_ready_o;
    assign w_last_idx = (idx_q == len_i - LEN_W'(1));
    assign seg_last_o = active_i && ((len_i == '0) || (w_beat && w_last_idx));

    // Register one write per accepted beat and track segment completion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q         <= '0;
            bram_din_o    <= '0;
            bram_addra_o  <= '0;
            bram_wea_o    <= 1'b0;
            h_data_ena_o  <= 1'b0;
            h_node_ena_o  <= 1'b0;
            wgt_ena_o     <= 1'b0;
            h_data_done_o <= 1'b0;
            h_node_done_o <= 1'b0;
            wgt_done_o    <= 1'b0;
        end else begin
            bram_wea_o   <= 1'b0;
            h_data_ena_o <= 1'b0;
            h_node_ena_o <= 1'b0;
            wgt_ena_o    <= 1'b0;
            if (w_beat) begin
                bram_wea_o   <= 1'b1;
                bram_din_o   <= s_data_i;
                bram_addra_o <= ADDR_W'({idx_q, {BYTE_SHIFT{1'b0}}});
                idx_q        <= w_last_idx ? '0 : idx_q + LEN_W'(1);
                case (seg_i)
                    SEG_H:    h_data_ena_o <= 1'b1;
                    SEG_NODE: h_node_ena_o <= 1'b1;
                    default:  wgt_ena_o    <= 1'b1;
                endcase
            end
            if (clear_i) begin
                idx_q         <= '0;
                h_data_done_o <= 1'b0;
                h_node_done_o <= 1'b0;
                wgt_done_o    <= 1'b0;
            end else if (seg_last_o) begin
                case (seg_i)
                    SEG_H:    h_data_done_o <= 1'b1;
                    SEG_NODE: h_node_done_o <= 1'b1;
                    default:  wgt_done_o    <= 1'b1;
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/gat_layer_scheduler.sv
//==============================================================================
// Module  : gat_layer_scheduler
// Brief   : Sequences one GAT layer run: load H/node/weight BRAMs from the
//           input stream, launch the core, wait for ready, drain features.
//           Optional RUN watchdog enabled by macro GAT_SCHED_TIMEOUT_EN.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module gat_layer_scheduler
    import gat_sched_pkg::*;
#(
    parameter int TOP_WIDTH = 32,
    parameter int LEN_W     = 20,
    parameter int ADDR_W    = 22,
    parameter int RD_LAT    = 2,
    parameter int TIMEOUT_W = 24
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [LEN_W-1:0]     cfg_h_len,
    input  logic [LEN_W-1:0]     cfg_node_len,
    input  logic [LEN_W-1:0]     cfg_wgt_len,
    input  logic [LEN_W-1:0]     cfg_feat_len,
    input  logic [TOP_WIDTH-1:0] s_data,
    input  logic                 s_valid,
    output logic                 s_ready,
    output logic [TOP_WIDTH-1:0] bram_din,
    output logic                 h_data_ena,
    output logic                 h_node_ena,
    output logic                 wgt_ena,
    output logic                 bram_wea,
    output logic [ADDR_W-1:0]    bram_addra,
    output logic                 h_data_load_done,
    output logic                 h_node_load_done,
    output logic                 wgt_load_done,
    output logic                 gat_layer,
    input  logic                 gat_ready,
    output logic [ADDR_W-1:0]    feat_addrb,
    input  logic [TOP_WIDTH-1:0] feat_dout,
    output logic [TOP_WIDTH-1:0] m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    localparam int WAIT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    if (RD_LAT < 1 || TIMEOUT_W < 1) begin : g_param_check
        $error("gat_layer_scheduler: RD_LAT and TIMEOUT_W must be at least 1");
    end

    state_e               state_q;
    logic [LEN_W-1:0]     h_len_q, node_len_q, wgt_len_q, feat_len_q, feat_idx_q;
    logic [WAIT_W-1:0]    wait_q;
    logic                 gat_ready_q, gat_layer_q, done_q, err_q, m_valid_q;
    logic [TOP_WIDTH-1:0] m_data_q;
    logic [ADDR_W-1:0]    feat_addrb_q;
`ifdef GAT_SCHED_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] to_cnt_q;
`endif

    seg_e             w_seg;
    logic [LEN_W-1:0] w_len;
    logic             w_active, w_seg_last, w_start_acc, w_len_ovf;
    logic             w_ready_rise, w_feat_last;
    logic [LEN_W-1:0] w_feat_next;

    assign w_start_acc  = (state_q == S_IDLE) && start;
    assign w_len_ovf    = len_overflows(64'(cfg_h_len), ADDR_W)
                        | len_overflows(64'(cfg_node_len), ADDR_W)
                        | len_overflows(64'(cfg_wgt_len), ADDR_W)
                        | len_overflows(64'(cfg_feat_len), ADDR_W);
    assign w_ready_rise = gat_ready && !gat_ready_q;
    assign w_feat_last  = (feat_idx_q == feat_len_q - LEN_W'(1));
    assign w_feat_next  = feat_idx_q + LEN_W'(1);

    // Route the latched length of the current load state to the loader
    always_comb begin
        w_seg    = SEG_H;
        w_len    = h_len_q;
        w_active = 1'b0;
        case (state_q)
            S_LD_H:    w_active = 1'b1;
            S_LD_NODE: begin w_seg = SEG_NODE; w_len = node_len_q; w_active = 1'b1; end
            S_LD_WGT:  begin w_seg = SEG_WGT;  w_len = wgt_len_q;  w_active = 1'b1; end
            default:   ;
        endcase
    end

    gat_sched_seg_loader #(
        .TOP_WIDTH (TOP_WIDTH),
        .LEN_W     (LEN_W),
        .ADDR_W    (ADDR_W)
    ) u_loader (
        .clk           (clk),
        .rst_n         (rst_n),
        .clear_i       (w_start_acc),
        .active_i      (w_active),
        .seg_i         (w_seg),
        .len_i         (w_len),
        .s_data_i      (s_data),
        .s_valid_i     (s_valid),
        .s_ready_o     (s_ready),
        .bram_din_o    (bram_din),
        .h_data_ena_o  (h_data_ena),
        .h_node_ena_o  (h_node_ena),
        .wgt_ena_o     (wgt_ena),
        .bram_wea_o    (bram_wea),
        .bram_addra_o  (bram_addra),
        .h_data_done_o (h_data_load_done),
        .h_node_done_o (h_node_load_done),
        .wgt_done_o    (wgt_load_done),
        .seg_last_o    (w_seg_last)
    );

    // Main sequencer with registered launch, drain and status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            h_len_q      <= '0;
            node_len_q   <= '0;
            wgt_len_q    <= '0;
            feat_len_q   <= '0;
            feat_idx_q   <= '0;
            wait_q       <= '0;
            gat_ready_q  <= 1'b0;
            gat_layer_q  <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            m_valid_q    <= 1'b0;
            m_data_q     <= '0;
            feat_addrb_q <= '0;
`ifdef GAT_SCHED_TIMEOUT_EN
            to_cnt_q     <= '0;
`endif
        end else begin
            gat_ready_q <= gat_ready;
            gat_layer_q <= 1'b0;
            done_q      <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        h_len_q    <= cfg_h_len;
                        node_len_q <= cfg_node_len;
                        wgt_len_q  <= cfg_wgt_len;
                        feat_len_q <= cfg_feat_len;
                        err_q      <= w_len_ovf;
                        state_q    <= S_LD_H;
                    end
                end
                S_LD_H:    if (w_seg_last) state_q <= S_LD_NODE;
                S_LD_NODE: if (w_seg_last) state_q <= S_LD_WGT;
                S_LD_WGT: begin
                    if (w_seg_last) begin
                        gat_layer_q <= 1'b1;
                        state_q     <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
`ifdef GAT_SCHED_TIMEOUT_EN
                    to_cnt_q <= '0;
`endif
                    state_q  <= S_RUN;
                end
                S_RUN: begin
                    if (w_ready_rise) begin
                        if (feat_len_q == '0) begin
                            done_q  <= 1'b1;
                            state_q <= S_IDLE;
                        end else begin
                            feat_idx_q   <= '0;
                            feat_addrb_q <= '0;
                            state_q      <= S_RD_ISSUE;
                        end
                    end
`ifdef GAT_SCHED_TIMEOUT_EN
                    else if (&(to_cnt_q + TIMEOUT_W'(1))) begin
                        err_q   <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        to_cnt_q <= to_cnt_q + TIMEOUT_W'(1);
                    end
`endif
                end
                S_RD_ISSUE: begin
                    wait_q  <= '0;
                    state_q <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    if (wait_q == WAIT_W'(RD_LAT - 1)) begin
                        m_data_q  <= feat_dout;
                        m_valid_q <= 1'b1;
                        state_q   <= S_RD_OUT;
                    end else begin
                        wait_q <= wait_q + WAIT_W'(1);
                    end
                end
                S_RD_OUT: begin
                    if (m_ready) begin
                        m_valid_q <= 1'b0;
                        if (w_feat_last) begin
                            done_q  <= 1'b1;
                            state_q <= S_IDLE;
                        end else begin
                            feat_idx_q   <= w_feat_next;
                            feat_addrb_q <= ADDR_W'({w_feat_next, {BYTE_SHIFT{1'b0}}});
                            state_q      <= S_RD_ISSUE;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign gat_layer  = gat_layer_q;
    assign done       = done_q;
    assign err        = err_q;
    assign m_valid    = m_valid_q;
    assign m_data     = m_data_q;
    assign feat_addrb = feat_addrb_q;
    assign busy       = (state_q != S_IDLE);

endmodule

`default_nettype wire
